// File: rtl/p13_debounce_sync.sv
// Per-lane debouncer for asynchronous button/switch inputs: a two-flop synchronizer
// feeds a saturating stability counter, and every committed level change is reported as a one-cycle edge pulse.
module p13_debounce_sync #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // The count at which the next differing sample commits the new level.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] dout_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  // While ena is low the lane state holds and no pulse can be generated.
  always_comb begin
    dout_nxt = dout;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
    end
    if (ena) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == dout[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          dout_nxt[i] = sync2[i];
          cnt_nxt[i]  = '0;
          rise_nxt[i] = sync2[i];
          fall_nxt[i] = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // The synchronizer runs every cycle so ena never widens the metastability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      dout    <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      dout    <= dout_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      changed <= |(rise_nxt | fall_nxt);
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: doc/p13_debounce_sync.md
P13_DEBOUNCE_SYNC -- requirements
Module: p13_debounce_sync

Interface
REQ-001 Parameter WIDTH, default 8, is the number of independent input lanes (1..8).
REQ-002 Parameter STABLE_CYCLES, default 15, is the number of consecutive differing samples that commits a new level (1..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset; assertion is asynchronous and clears all state.
REQ-005 ena  input  1  count enable; low freezes debounce state.
REQ-006 din  input  WIDTH  raw lanes, asynchronous to clk (buttons, switches).
REQ-007 dout  output  WIDTH  debounced, registered level per lane.
REQ-008 rise  output  WIDTH  one-cycle pulse per lane when dout goes 0->1.
REQ-009 fall  output  WIDTH  one-cycle pulse per lane when dout goes 1->0.
REQ-010 changed  output  1  OR-reduction of rise and fall, registered alongside them.

Function
REQ-011 Each lane SHALL pass din through a two-flop synchronizer (sync1, sync2) clocked every cycle regardless of ena.
REQ-012 Each lane SHALL hold a counter of width ceil(log2(STABLE_CYCLES+1)) that never wraps.
REQ-013 At an edge with ena=1 where sync2 equals dout, the lane counter SHALL clear to 0.
REQ-014 At an edge with ena=1 where sync2 differs from dout and counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 At an edge with ena=1 where sync2 differs from dout and counter = STABLE_CYCLES-1, dout SHALL take sync2, the counter SHALL clear, and rise or fall SHALL be 1 in the following cycle.
REQ-016 Latency: a din change held stable, first sampled by sync1 at edge 0, SHALL appear on dout after edge STABLE_CYCLES+1, with ena high throughout.
REQ-017 A glitch on one lane shorter than the commit window SHALL NOT change dout or pulse rise, fall or changed.
REQ-018 With STABLE_CYCLES=1, dout SHALL follow sync2 with one cycle of delay.
REQ-019 With ena=0, counters and dout SHALL hold, and rise, fall and changed SHALL be 0 at the next edge.
REQ-020 rise, fall and changed SHALL each be high for exactly one cycle per commit and SHALL never be high on the same lane simultaneously.
REQ-021 Lanes SHALL be fully independent; commits on several lanes in the same cycle are all reported.

Reset
REQ-022 While rst_n=0: sync1, sync2, counters, dout, rise, fall and changed SHALL all be 0.
REQ-023 After rst_n deasserts with din lanes high, those lanes SHALL commit to 1 through the normal path (REQ-016) and pulse rise.
REQ-024 Asserting rst_n mid-count SHALL discard partial counts; no pulse is emitted for the aborted transition.

Verification
REQ-025 Defaults, din 0x00->0x01 held, ena=1 -> dout=0x01 after edge 16 counted from the first sampling edge; rise=0x01 and changed=1 for one cycle; fall=0.
REQ-026 din[3] pulses high for 10 cycles, then returns low -> dout, rise and changed remain 0 throughout.
REQ-027 dout=0xFF, din 0xFF->0x0F held -> fall=0xF0 in a single cycle; dout=0x0F.
REQ-028 din changes, ena drops after 8 counting cycles for 20 cycles, then returns high -> dout commits 7 counting cycles after ena re-rises; no pulse while ena is low.
REQ-029 rst_n pulsed low at count 10 of a pending 0->1 with din still high -> all outputs 0 during reset; a full 17-edge latency runs again after release, followed by a single rise pulse.
REQ-030 STABLE_CYCLES=1, din toggled every 4 cycles -> dout tracks din delayed by 3 edges, with one pulse per toggle.
